spi_target_phy: RTL and testbench
=================================

// Module: spi_target_phy
//
// PURPOSE
//   Peripheral (target) end of the SPI physical layer, the counterpart of the controller-side spi_phy.
//   Runs in SPI mode 0 (CPOL=0, CPHA=0). It oversamples the external CS/SCLK/COPI lines in i_clk.
//   It deframes WIDTH-bit words MSB-first onto a ready/read port and serializes queued words onto CIPO.
//   Sits between the FPGA pins and the host-facing register or command logic.
//
// PARAMETERS
//   WIDTH  8      bits per frame (>= 2)
//   PAD    8'h00  word sent on CIPO when no TX word is queued at frame load (WIDTH bits)
//
// PORTS
//   i_clk      in   1      system clock; sole clock domain
//   i_rst      in   1      reset, asynchronous, active-high
//   s_cs       in   1      SPI chip select, active-low, asynchronous to i_clk
//   s_clk      in   1      SPI clock, asynchronous to i_clk
//   s_copi     in   1      controller-out/peripheral-in serial data
//   s_cipo     out  1      controller-in/peripheral-out serial data
//   s_cipo_oe  out  1      CIPO output enable; high only while synchronized CS is low
//   o_rdata    out  WIDTH  last complete received word
//   o_rdy      out  1      o_rdata holds an unread word
//   i_rd       in   1      consume o_rdata; clears o_rdy and o_ovr
//   o_ovr      out  1      sticky overrun: a word completed while o_rdy=1 and i_rd=0
//   o_bsy      out  1      TX holding register full; i_wr is ignored
//   i_wr       in   1      queue i_wdata for transmission (accepted only when o_bsy=0)
//   i_wdata    in   WIDTH  word to transmit
//
// BEHAVIOUR
//   - Reset (async): every output and register is 0, o_rdata = 0, TX shift register = PAD, state IDLE.
//   - Input sync: s_cs, s_clk and s_copi each pass through a 2-flop synchronizer, plus one history flop for edge detect.
//     rise = sclk_s & ~sclk_q; fall = ~sclk_s & sclk_q.
//   - Rate limit: SCLK high/low phases must each be >= 4 i_clk. Faster SCLK is unsupported and unchecked.
//   - FSM IDLE: entered while cs_s = 1. Bit counter = 0, RX partial is discarded, s_cipo_oe = 0.
//   - IDLE -> ACTIVE on the cycle cs_s falls:
//       load TX shift register from holding if holding is full (clear it, so o_bsy falls next cycle), else load PAD;
//       s_cipo = MSB of the loaded word.
//   - ACTIVE, rise:
//       shift copi_s into the RX shift register LSB; increment the bit counter.
//       At count WIDTH-1: o_rdata <= {rx[WIDTH-2:0], copi_s}, o_rdy <= 1, count <= 0, set frame_done.
//   - ACTIVE, fall:
//       if frame_done, reload the TX shift register as at CS fall and clear frame_done;
//       otherwise shift TX left by 1. s_cipo always tracks the TX MSB.
//   - ACTIVE -> IDLE on cs_s rising, at any bit position:
//       the partial RX word is dropped and the o_rdy/o_rdata of prior frames is kept;
//       a TX word already moved to the shift register is lost; the holding register is untouched.
//   - Handshakes:
//       i_rd with o_rdy=0 is a no-op.
//       i_rd in the same cycle as a completion: o_rdy stays 1 with the new word, and o_ovr is neither set nor kept.
//       Completion while o_rdy=1 and i_rd=0: o_rdata is overwritten and o_ovr <= 1.
//       i_wr with o_bsy=0 latches i_wdata, and o_bsy = 1 from the next cycle.
//       i_wr with o_bsy=1 is ignored, with no error.
//       i_wr in the same cycle as a load while holding is empty: the load takes PAD and the write lands in holding.
//   - Latency:
//       o_rdy is asserted 1 i_clk after the synchronized last rise, which is 3 i_clk after the pin edge.
//       The CIPO bit changes 3 i_clk after the pin SCLK fall or CS fall.
//   - All counters use clog2(WIDTH) bits. The bit counter wraps only at completion or on CS high.
//
// STRUCTURE
//   - Shared spi package: mode-0 constant and the default WIDTH, both shared with spi_phy.
//   - One sub-module: spi_sync (2-flop synchronizer plus edge detect), instanced for s_cs and s_clk (edges) and for s_copi (level).
//   - Everything else is inline: FSM, RX and TX shift registers, holding register, flags.
//
// TESTING  (bench SPI-controller model, SCLK half-period = 8 i_clk, WIDTH=8)
//   1. Async reset mid-frame -> all outputs 0 immediately; the next full frame 8'hA5 -> o_rdata=A5, o_rdy=1.
//   2. Queue 8'h9B, then a frame with COPI=8'h53 -> CIPO captured = 9B, o_rdata=53, o_bsy falls 1 cycle after CS fall.
//   3. Two back-to-back frames (74, 3C) with no i_rd -> o_rdata=3C, o_ovr=1; after one i_rd -> o_rdy=0, o_ovr=0.
//   4. No TX queued, frame COPI=00 -> CIPO=PAD (00). Queue 0xE1 during bit 3, 2-frame burst -> CIPO = 00 then E1.
//   5. CS rises after 5 bits -> o_rdy stays 0; the next 8-bit frame 8'hC3 -> o_rdata=C3 (no stale bits).
//   6. i_rd asserted on the completion cycle of the second frame -> o_rdy=1, o_ovr=0. i_wr with o_bsy=1 -> holding unchanged.

Source files
------------

// File: rtl/spi_target_phy_pkg.sv
// Definitions shared by the SPI physical layers (controller and target side).
// Both ends agree on the clock mode and on the default frame width.
package spi_target_phy_pkg;

  localparam logic       SPI_CPOL  = 1'b0;
  localparam logic       SPI_CPHA  = 1'b0;
  localparam logic [1:0] SPI_MODE  = {SPI_CPOL, SPI_CPHA};
  localparam int         SPI_WIDTH = 8;

endpackage

// File: rtl/spi_target_phy_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin.
// A third history flop provides single-cycle rise and fall strobes.
module spi_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/spi_target_phy.sv
// SPI mode-0 target: oversamples CS/SCLK/COPI in i_clk, deframes MSB-first
// words onto a ready/read port and serializes queued words onto CIPO.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | CS high; bit counter cleared, CIPO driver off
// ST_ACTIVE | CS low; sample COPI on SCLK rise, shift CIPO on SCLK fall
module spi_target_phy
  import spi_target_phy_pkg::*;
#(
  parameter int               WIDTH = SPI_WIDTH,
  parameter logic [WIDTH-1:0] PAD   = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             s_cs,
  input  logic             s_clk,
  input  logic             s_copi,
  output logic             s_cipo,
  output logic             s_cipo_oe,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rdy,
  input  logic             i_rd,
  output logic             o_ovr,
  output logic             o_bsy,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  logic cs_s, cs_fall, cs_rise_unused;
  logic sclk_s_unused, sclk_rise, sclk_fall;
  logic copi_s, copi_rise_unused, copi_fall_unused;

  logic             state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-2:0] rx_sr;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             frame_done;

  logic             active;
  logic             done_rise;
  logic             load;
  logic             wr_acc;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] rx_next;

  spi_sync u_sync_cs (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .d     (s_cs),
    .q     (cs_s),
    .rise  (cs_rise_unused),
    .fall  (cs_fall)
  );

  spi_sync u_sync_sclk (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .d     (s_clk),
    .q     (sclk_s_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync u_sync_copi (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .d     (s_copi),
    .q     (copi_s),
    .rise  (copi_rise_unused),
    .fall  (copi_fall_unused)
  );

  always_comb begin
    active    = (state == ST_ACTIVE) && !cs_s;
    done_rise = active && sclk_rise && (bit_cnt == LAST);
    load      = ((state == ST_IDLE) && cs_fall) || (active && sclk_fall && frame_done);
    load_word = hold_full ? hold : PAD;
    wr_acc    = i_wr && !hold_full;
    rx_next   = {rx_sr, copi_s};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= PAD;
      frame_done <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        bit_cnt    <= '0;
        rx_sr      <= '0;
        frame_done <= 1'b0;
        if (cs_fall) state <= ST_ACTIVE;
      end else if (cs_s) begin
        // Aborted frame: partial RX bits and the in-flight TX word are dropped.
        state      <= ST_IDLE;
        bit_cnt    <= '0;
        frame_done <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_sr <= rx_next[WIDTH-2:0];
          if (bit_cnt == LAST) begin
            bit_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        if (sclk_fall) begin
          if (frame_done) frame_done <= 1'b0;
          else            tx_sr      <= tx_sr << 1;
        end
      end
      if (load) tx_sr <= load_word;
    end
  end

  // A write and a load never both act on the holding register: writes need it empty, takes need it full.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (wr_acc) begin
      hold      <= i_wdata;
      hold_full <= 1'b1;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdata <= '0;
      o_rdy   <= 1'b0;
      o_ovr   <= 1'b0;
    end else if (done_rise) begin
      o_rdata <= rx_next;
      o_rdy   <= 1'b1;
      o_ovr   <= o_rdy && !i_rd;
    end else if (i_rd) begin
      o_rdy <= 1'b0;
      o_ovr <= 1'b0;
    end
  end

  assign s_cipo    = tx_sr[WIDTH-1];
  assign s_cipo_oe = (state == ST_ACTIVE) && !cs_s;
  assign o_bsy     = hold_full;

endmodule

// File: tb/tb_spi_target_phy.sv
// Directed bench for spi_target_phy: an SPI mode-0 controller model drives
// frames while a monitor checks every delivered RX word against a queue.
module tb_spi_target_phy;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       s_cs, s_clk, s_copi;
  logic       s_cipo, s_cipo_oe;
  logic [7:0] o_rdata;
  logic       o_rdy, i_rd, o_ovr, o_bsy, i_wr;
  logic [7:0] i_wdata;

  typedef struct {
    logic [7:0] d;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 i_clk = ~i_clk;

  spi_target_phy #(.WIDTH(8), .PAD(8'h00)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .s_cs      (s_cs),
    .s_clk     (s_clk),
    .s_copi    (s_copi),
    .s_cipo    (s_cipo),
    .s_cipo_oe (s_cipo_oe),
    .o_rdata   (o_rdata),
    .o_rdy     (o_rdy),
    .i_rd      (i_rd),
    .o_ovr     (o_ovr),
    .o_bsy     (o_bsy),
    .i_wr      (i_wr),
    .i_wdata   (i_wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic ovr);
    exp_t e;
    e.d   = d;
    e.ovr = ovr;
    exp_q.push_back(e);
  endtask

  task automatic do_rd();
    i_rd = 1'b1;
    @(negedge i_clk);
    i_rd = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic do_wr(input logic [7:0] v);
    i_wr    = 1'b1;
    i_wdata = v;
    @(negedge i_clk);
    i_wr = 1'b0;
    @(negedge i_clk);
  endtask

  // Mode-0 controller: COPI changes with SCLK low, CIPO sampled just before each rise.
  task automatic spi_frame(input logic [7:0] tx, input int nbits, input bit keep_cs,
                           input int wr_bit, input logic [7:0] wr_val, input bit rd_last,
                           output logic [7:0] cap);
    cap  = 8'h00;
    s_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      s_copi = tx[7-i];
      if (i == wr_bit) begin
        i_wr    = 1'b1;
        i_wdata = wr_val;
        @(negedge i_clk);
        i_wr = 1'b0;
        repeat (7) @(negedge i_clk);
      end else begin
        repeat (8) @(negedge i_clk);
      end
      cap   = {cap[6:0], s_cipo};
      s_clk = 1'b1;
      if (rd_last && i == nbits - 1) begin
        repeat (2) @(negedge i_clk);
        i_rd = 1'b1;
        @(negedge i_clk);
        i_rd = 1'b0;
        repeat (5) @(negedge i_clk);
      end else begin
        repeat (8) @(negedge i_clk);
      end
      s_clk = 1'b0;
    end
    if (!keep_cs) begin
      repeat (8) @(negedge i_clk);
      s_cs = 1'b1;
      repeat (8) @(negedge i_clk);
    end
  endtask

  // Scoreboard monitor: a new word is o_rdy rising or o_rdata changing while ready.
  initial begin
    logic       prev_rdy;
    logic [7:0] prev_rdata;
    exp_t       e;
    prev_rdy   = 1'b0;
    prev_rdata = 8'h00;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_rdy   = 1'b0;
        prev_rdata = 8'h00;
      end else begin
        if (o_rdy && (!prev_rdy || o_rdata !== prev_rdata)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got 0x%0h, expected no word", o_rdata);
          end else begin
            e = exp_q.pop_front();
            chk("rx_data", 32'(o_rdata), 32'(e.d));
            chk("rx_ovr", 32'(o_ovr), 32'(e.ovr));
          end
        end
        prev_rdy   = o_rdy;
        prev_rdata = o_rdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cap, cap2;
    i_rst = 1'b1; s_cs = 1'b1; s_clk = 1'b0; s_copi = 1'b0;
    i_rd = 1'b0; i_wr = 1'b0; i_wdata = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("rst_rdy", 32'(o_rdy), 32'h0);
    chk("rst_rdata", 32'(o_rdata), 32'h0);
    chk("rst_bsy", 32'(o_bsy), 32'h0);
    chk("rst_oe", 32'(s_cipo_oe), 32'h0);
    i_rst = 1'b0;
    repeat (5) @(negedge i_clk);

    // 1: async reset in the middle of a frame, then a clean frame
    push(8'h5A, 1'b0);
    spi_frame(8'h5A, 8, 1'b0, -1, 8'h00, 1'b0, cap);
    spi_frame(8'hFF, 4, 1'b1, -1, 8'h00, 1'b0, cap);
    do_wr(8'h77);
    #3 i_rst = 1'b1;
    #1;
    chk("arst_rdy", 32'(o_rdy), 32'h0);
    chk("arst_rdata", 32'(o_rdata), 32'h0);
    chk("arst_bsy", 32'(o_bsy), 32'h0);
    chk("arst_oe", 32'(s_cipo_oe), 32'h0);
    chk("arst_cipo", 32'(s_cipo), 32'h0);
    @(negedge i_clk);
    s_cs = 1'b1; s_clk = 1'b0; s_copi = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (10) @(negedge i_clk);
    push(8'hA5, 1'b0);
    spi_frame(8'hA5, 8, 1'b0, -1, 8'h00, 1'b0, cap);
    chk("t1_rdy", 32'(o_rdy), 32'h1);
    chk("t1_cipo_pad", 32'(cap), 32'h00);
    do_rd();

    // 2: queued word goes out on CIPO; o_bsy drops one cycle after synchronized CS fall
    do_wr(8'h9B);
    chk("t2_bsy_set", 32'(o_bsy), 32'h1);
    push(8'h53, 1'b0);
    s_cs = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("t2_bsy_pre", 32'(o_bsy), 32'h1);
    chk("t2_cipo_pre", 32'(s_cipo), 32'h0);
    chk("t2_oe_pre", 32'(s_cipo_oe), 32'h0);
    @(negedge i_clk);
    chk("t2_bsy_post", 32'(o_bsy), 32'h0);
    chk("t2_cipo_post", 32'(s_cipo), 32'h1);
    chk("t2_oe_post", 32'(s_cipo_oe), 32'h1);
    spi_frame(8'h53, 8, 1'b0, -1, 8'h00, 1'b0, cap);
    chk("t2_cipo_word", 32'(cap), 32'h9B);
    do_rd();

    // 3: overrun on an unread word, cleared by one read
    push(8'h74, 1'b0);
    spi_frame(8'h74, 8, 1'b0, -1, 8'h00, 1'b0, cap);
    push(8'h3C, 1'b1);
    spi_frame(8'h3C, 8, 1'b0, -1, 8'h00, 1'b0, cap);
    chk("t3_rdy", 32'(o_rdy), 32'h1);
    chk("t3_ovr", 32'(o_ovr), 32'h1);
    do_rd();
    chk("t3_rdy_rd", 32'(o_rdy), 32'h0);
    chk("t3_ovr_rd", 32'(o_ovr), 32'h0);

    // 4: PAD when nothing is queued; word queued mid-frame goes out in the next frame of a burst
    push(8'h00, 1'b0);
    spi_frame(8'h00, 8, 1'b0, -1, 8'h00, 1'b0, cap);
    chk("t4_cipo_pad", 32'(cap), 32'h00);
    do_rd();
    push(8'h11, 1'b0);
    push(8'h22, 1'b1);
    spi_frame(8'h11, 8, 1'b1, 3, 8'hE1, 1'b0, cap);
    spi_frame(8'h22, 8, 1'b0, -1, 8'h00, 1'b0, cap2);
    chk("t4_burst0", 32'(cap), 32'h00);
    chk("t4_burst1", 32'(cap2), 32'hE1);
    chk("t4_bsy", 32'(o_bsy), 32'h0);
    chk("t4_oe_idle", 32'(s_cipo_oe), 32'h0);
    do_rd();

    // 5: aborted 5-bit frame leaves nothing behind
    spi_frame(8'hF8, 5, 1'b0, -1, 8'h00, 1'b0, cap);
    chk("t5_rdy_abort", 32'(o_rdy), 32'h0);
    push(8'hC3, 1'b0);
    spi_frame(8'hC3, 8, 1'b0, -1, 8'h00, 1'b0, cap);
    do_rd();

    // 6: read on the completion cycle; write while busy is ignored
    push(8'h96, 1'b0);
    spi_frame(8'h96, 8, 1'b0, -1, 8'h00, 1'b0, cap);
    push(8'h69, 1'b0);
    spi_frame(8'h69, 8, 1'b0, -1, 8'h00, 1'b1, cap);
    chk("t6_rdy", 32'(o_rdy), 32'h1);
    chk("t6_ovr", 32'(o_ovr), 32'h0);
    do_rd();
    do_wr(8'h5C);
    chk("t6_bsy", 32'(o_bsy), 32'h1);
    do_wr(8'hA7);
    chk("t6_bsy_hold", 32'(o_bsy), 32'h1);
    push(8'h0F, 1'b0);
    spi_frame(8'h0F, 8, 1'b0, -1, 8'h00, 1'b0, cap);
    chk("t6_cipo_hold", 32'(cap), 32'h5C);
    do_rd();

    repeat (20) @(negedge i_clk);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
